csa_seq_add: RTL and testbench
==============================

# csa_seq_add

Sequential wide adder that time-shares one `csa_8` carry-select adder over a WIDTH-bit operand pair. It walks the operands byte by byte, least-significant byte first, and chains the carry between bytes. It uses two adder passes per byte: operand add, then carry-in fold. It sits in front of the existing 8-bit datapath and gives wide addition with valid/ready handshakes on both sides, at the cost of latency.

## Interface
- `WIDTH`, default 32: operand width; must be a multiple of 8 and at least 8; NB = WIDTH/8.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operand request.
- `in_ready` output 1: block can accept; high only in IDLE.
- `a` input WIDTH: operand A, sampled at accept.
- `b` input WIDTH: operand B, sampled at accept.
- `cin` input 1: initial carry-in, sampled at accept.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts result.
- `sum` output WIDTH: (a+b+cin) mod 2^WIDTH.
- `cout` output 1: bit WIDTH of a+b+cin.

## Operation
- States are IDLE, ADD, INC and DONE. The byte index `idx` is a counter of width $clog2(NB), minimum 1.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, register `a`, `b` and `cin` (carry register `c`), clear `idx`, and go to ADD.
  - Inputs may change after the accept edge.
- ADD:
  - Drive the `csa_8` inputs with `a[idx]` and `b[idx]`.
  - Register the partial byte `p` and carry `c1`. Go to INC.
- INC:
  - Drive the `csa_8` inputs with `p` and {7'b0, `c`}.
  - Write the result byte into `sum[idx]`. Set `c` to `c1` | `c2`.
  - `c1` and `c2` are never both 1: if `c1`=1 then `p`≤254.
  - If `idx`==NB-1, go to DONE. Otherwise increment `idx` and return to ADD.
- DONE:
  - `out_valid`=1, `cout`=`c`.
  - `sum` and `cout` are held stable until `out_valid`&&`out_ready`, then go to IDLE.
- The operand mux is combinational and feeds one `csa_8` instance. It selects byte operands in ADD and the carry fold in INC. In IDLE and DONE the mux drives 0.
- The `sum` register is written only byte-wise. Stale upper bytes from a previous operation are never visible, because DONE is reached only after all bytes are rewritten.

## Timing
- Reset values: `in_ready`=0 while `rst_n` is low, then 1 from the first cycle in IDLE. `out_valid`=0, `sum`=0, `cout`=0. State is IDLE, `idx`=0.
- Latency without the macro: `out_valid` rises exactly 2·NB cycles after the accept edge. For WIDTH=32 this is 8 cycles.
- Throughput: one operation per 2·NB+2 cycles when `out_ready` is held high. The +2 covers one DONE cycle and one IDLE cycle.
- Back-pressure: when `out_ready`=0 in DONE, the block stalls indefinitely with outputs frozen and `in_ready`=0.
- `in_valid` while busy is ignored; it is neither consumed nor queued.
- Reset mid-operation: asserting `rst_n` low at any point returns the block to IDLE immediately and clears all outputs. The in-flight operation is discarded and never reported.
- Wrap-around: carry out of byte NB-1 goes only to `cout`, and `sum` wraps modulo 2^WIDTH.

## Configuration
- `CSA_SEQ_SKIP_EN` defined:
  - In ADD with `c`=0, the INC pass is skipped. `sum[idx]` is set to the csa_8 sum and `c` to `c1`, and the block advances directly to the next byte, or to DONE after the last byte.
  - Latency becomes NB + (number of bytes entered with `c`=1).
- Without the macro: latency is always 2·NB and data-independent.
- Results are bit-identical in both builds.

## Structure
- Package `csa_seq_pkg`:
  - the `BYTE_W`=8 localparam;
  - the state enum typedef (IDLE, ADD, INC, DONE), 2 bits.
- Sub-module: the existing `csa_8`, instantiated once. No new sub-module.
- Everything else is one sequential process plus the combinational operand mux.

## Test plan
All scenarios use WIDTH=32, with the latency check matched to the build.
- 0x00000000+0x00000000, `cin`=0 → `sum`=0x00000000, `cout`=0. `out_valid` rises 8 cycles after accept (no macro), or 4 cycles (SKIP_EN).
- 0xFFFFFFFF+0x00000001, `cin`=0 → `sum`=0x00000000, `cout`=1. Latency is 8 (no macro) or 7 (SKIP_EN).
- 0x12345678+0x11111111, `cin`=1 → `sum`=0x2345678A, `cout`=0. Then 0x80000000+0x80000000, `cin`=0 → `sum`=0, `cout`=1.
- Hold `out_ready`=0 for 5 cycles in DONE, with `a`/`b` toggling and `in_valid`=1 → `sum`, `cout` and `out_valid` stay stable and `in_ready` stays 0. Release → the handshake completes and `in_ready`=1 the next cycle.
- Pull `rst_n` low 3 cycles after accept of 0xFFFFFFFF+0xFFFFFFFF → `out_valid`=0, `sum`=0, `cout`=0 immediately. After release, 0x000000FF+0x00000001 → `sum`=0x00000100, `cout`=0.
- 200 random back-to-back operations with `in_valid` and `out_ready` held at 1 → every result matches a+b+cin, and accepts are spaced 10 cycles apart (no macro).

Source files
------------

// File: rtl/csa_seq_pkg.sv
// Shared types for the sequential carry-select wide adder.
// Byte width and FSM state encoding.
package csa_seq_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    INC  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/csa_seq_add_csa_8.sv
// 8-bit carry-select adder: ripple low nibble,
// high nibble precomputed for both carries.
module csa_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  assign lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
  assign hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
  assign hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;

  assign sum  = {lo[4] ? hi1[3:0] : hi0[3:0], lo[3:0]};
  assign cout = lo[4] ? hi1[4] : hi0[4];
endmodule

// File: rtl/csa_seq_add.sv
// Wide adder time-sharing one csa_8, byte-serial LSB first.
// CSA_SEQ_SKIP_EN: skip the carry-fold pass when carry is 0.
module csa_seq_add
  import csa_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NB = WIDTH / BYTE_W;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  sum_q;
  logic [BYTE_W-1:0] p;
  logic              c;
  logic              c1;
  logic [IW-1:0]     idx;
  logic              last;
  logic              skip;

  logic [BYTE_W-1:0] op_a;
  logic [BYTE_W-1:0] op_b;
  logic [BYTE_W-1:0] s8;
  logic              co8;

  assign last = (idx == IW'(NB - 1));

`ifdef CSA_SEQ_SKIP_EN
  assign skip = ~c;
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    op_a = '0;
    op_b = '0;
    unique case (1'b1)
      state == ADD: begin
        op_a = a_q[idx*BYTE_W +: BYTE_W];
        op_b = b_q[idx*BYTE_W +: BYTE_W];
      end
      state == INC: begin
        op_a = p;
        op_b = {{(BYTE_W-1){1'b0}}, c};
      end
      default: ;
    endcase
  end

  csa_8 u_csa (
    .a    (op_a),
    .b    (op_b),
    .cin  (1'b0),
    .sum  (s8),
    .cout (co8)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = ADD;
      ADD: begin
        if (!skip)    state_nx = INC;
        else if (last) state_nx = DONE;
      end
      INC:  state_nx = last ? DONE : ADD;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      p     <= '0;
      c     <= 1'b0;
      c1    <= 1'b0;
      idx   <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          a_q <= a;
          b_q <= b;
          c   <= cin;
          idx <= '0;
        end
        ADD: begin
          if (skip) begin
            sum_q[idx*BYTE_W +: BYTE_W] <= s8;
            c <= co8;
            if (!last) idx <= idx + IW'(1);
          end else begin
            p  <= s8;
            c1 <= co8;
          end
        end
        INC: begin
          // c1 and the fold carry are mutually exclusive
          sum_q[idx*BYTE_W +: BYTE_W] <= s8;
          c <= c1 | co8;
          if (!last) idx <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = rst_n & (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign cout      = c;
endmodule

// File: tb/tb_csa_seq_add.sv
// Directed and back-to-back checks for csa_seq_add, WIDTH=32.
// Latency expectations follow CSA_SEQ_SKIP_EN when defined.
module tb_csa_seq_add;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;

  int cmp = 0;
  int err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  csa_seq_add #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  // Accept one op, return cycles to out_valid; leaves DUT in DONE.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic ci, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    cmp++;
    if (!in_ready) begin
      err++;
      $display("FAIL accept_wait in_ready=%b required 1", in_ready);
    end
    a = av; b = bv; cin = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string nm, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic ci,
                          input logic [W-1:0] es, input logic ec,
                          input int elat);
    int lat;
    start_op(av, bv, ci, lat);
    cmp++;
    if (sum !== es || cout !== ec || out_valid !== 1'b1) begin
      err++;
      $display("FAIL %s sum=%h cout=%b ov=%b required sum=%h cout=%b ov=1",
               nm, sum, cout, out_valid, es, ec);
    end
    if (elat > 0) begin
      cmp++;
      if (lat !== elat) begin
        err++;
        $display("FAIL %s_latency got=%0d required=%0d", nm, lat, elat);
      end
    end
    finish_op();
  endtask

  task automatic test_reset();
    #2;
    cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      err++;
      $display("FAIL reset_state ir=%b ov=%b sum=%h cout=%b required 0 0 0 0",
               in_ready, out_valid, sum, cout);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      err++;
      $display("FAIL reset_release ir=%b ov=%b required ir=1 ov=0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
`ifdef CSA_SEQ_SKIP_EN
    check_op("zero", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 4);
    check_op("wrap", 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b1, 7);
`else
    check_op("zero", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 8);
    check_op("wrap", 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b1, 8);
`endif
    check_op("cin1", 32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 0);
    check_op("msb", 32'h80000000, 32'h80000000, 1'b0, 32'h0, 1'b1, 0);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W-1:0] hs;
    logic hc;
    start_op(32'hDEADBEEF, 32'h01020304, 1'b1, lat);
    hs = sum; hc = cout;
    cmp++;
    if (hs !== 32'hDFAFC1F4 || hc !== 1'b0) begin
      err++;
      $display("FAIL bp_result sum=%h cout=%b required sum=dfafc1f4 cout=0", hs, hc);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = ~a; b = b + 32'h5; cin = ~cin;
      @(posedge clk); #1;
      cmp++;
      if (sum !== hs || cout !== hc || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        err++;
        $display("FAIL bp_hold%0d sum=%h cout=%b ov=%b ir=%b required %h %b 1 0",
                 i, sum, cout, out_valid, in_ready, hs, hc);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      err++;
      $display("FAIL bp_release ov=%b ir=%b required ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    cmp++;
    if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || in_ready !== 1'b0) begin
      err++;
      $display("FAIL mid_reset ov=%b sum=%h cout=%b ir=%b required 0 0 0 0",
               out_valid, sum, cout, in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_op("post_reset", 32'h000000FF, 32'h1, 1'b0, 32'h00000100, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    logic [W:0] q[$];
    logic [W:0] e;
    logic [W:0] got;
    int done_n, acc_n, last_acc, guard;
    logic acc, fin;
    done_n = 0; acc_n = 0; last_acc = -1; guard = 0;
    a = $urandom; b = $urandom; cin = 1'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    while (done_n < 200 && guard < 5000) begin
      @(negedge clk);
      acc = in_ready && in_valid;
      fin = out_valid;
      got = {cout, sum};
      if (acc) q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        acc_n++;
`ifndef CSA_SEQ_SKIP_EN
        if (last_acc >= 0) begin
          cmp++;
          if (cyc - last_acc !== 10) begin
            err++;
            $display("FAIL b2b_spacing op=%0d got=%0d required=10", acc_n, cyc - last_acc);
          end
        end
`endif
        last_acc = cyc;
        a = $urandom; b = $urandom; cin = 1'($urandom);
        if (acc_n >= 200) in_valid = 1'b0;
      end
      if (fin) begin
        e = q.size() > 0 ? q.pop_front() : '0;
        cmp++;
        if (got !== e) begin
          err++;
          $display("FAIL b2b_result op=%0d got=%h required=%h", done_n, got, e);
        end
        done_n++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    cmp++;
    if (done_n !== 200) begin
      err++;
      $display("FAIL b2b_count got=%0d required=200", done_n);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
